avmm_master_arbiter: RTL

- Two-requester Avalon-MM arbiter that lets the wordcopy master and the dot-product accelerator master share the single SDRAM master port.
- Round-robin arbitration with grant locking while the downstream port stalls.
- Pipelined reads: tracks outstanding reads in order and routes each readdatavalid beat back to the requester that issued the read.

---
 rtl/avmm_arb_pkg.sv | 17 +
 rtl/avmm_arb_resp_id_fifo.sv | 59 +++++
 rtl/avmm_master_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/avmm_arb_pkg.sv
// Shared types and helpers for the two-requester Avalon-MM arbiter.
// No logic; types and constants only.
// Not applicable.
package avmm_arb_pkg;

    // Requester identifier: 0 = wordcopy master, 1 = dot-product master
    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // Width needed to hold an occupancy count from 0 up to max_out inclusive
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out) + 1;
    endfunction

endpackage

// File: rtl/avmm_arb_resp_id_fifo.sv
// In-order record of which requester issued each outstanding read.
// Latency: dout shows the head combinationally; push/pop take effect at the clock edge.
// Backpressure: a push while full is accepted only together with a pop.
module resp_id_fifo
    import avmm_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  req_id_t          din,
    output req_id_t          dout,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/avmm_master_arbiter.sv
// Round-robin share of one SDRAM Avalon-MM port between two masters, with in-order read return routing.
// Latency: zero-cycle command forwarding and zero-cycle readdata routing.
// Backpressure: grant locks while ds_waitrequest stalls; reads also stall when MAX_OUTSTANDING are in flight.
module avmm_master_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ds_address,
    output logic              ds_read,
    output logic              ds_write,
    output logic [DATA_W-1:0] ds_writedata,
    input  logic              ds_waitrequest,
    input  logic [DATA_W-1:0] ds_readdata,
    input  logic              ds_readdatavalid,
    output logic              resp_err
);

    localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

    logic             rst_q;
    logic             in_rst;
    logic             req0;
    logic             req1;
    logic             locked;
    req_id_t          lock_id;
    req_id_t          last;
    req_id_t          grant;
    logic             gnt_vld;
    logic             cmd_ok;
    logic             sel_read;
    logic             sel_write;
    logic             blocked;
    logic             accept;
    logic             push;
    logic             pop;
    req_id_t          pop_id;
    logic [CNT_W-1:0] count;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Hold off all traffic for the reset cycle and the one after it
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end
    assign in_rst = rst | rst_q;

    // Grant selection: a stalled command keeps its grant, otherwise round-robin on ties
    always_comb begin
        grant   = REQ0;
        gnt_vld = 1'b0;
        if (locked) begin
            grant   = lock_id;
            gnt_vld = 1'b1;
        end else if (req0 && req1) begin
            grant   = ~last;
            gnt_vld = 1'b1;
        end else if (req0) begin
            grant   = REQ0;
            gnt_vld = 1'b1;
        end else if (req1) begin
            grant   = REQ1;
            gnt_vld = 1'b1;
        end
    end

    assign cmd_ok    = gnt_vld & ~in_rst;
    assign sel_read  = (grant == REQ1) ? m1_read  : m0_read;
    assign sel_write = (grant == REQ1) ? m1_write : m0_write;

    // A response popping this cycle frees a slot, so a full tracker may still take a read
    assign pop     = ds_readdatavalid & (count != '0);
    assign blocked = sel_read & (count == CNT_W'(MAX_OUTSTANDING)) & ~pop;

    assign ds_read      = cmd_ok & sel_read & ~blocked;
    assign ds_write     = cmd_ok & sel_write;
    assign ds_address   = (grant == REQ1) ? m1_address   : m0_address;
    assign ds_writedata = (grant == REQ1) ? m1_writedata : m0_writedata;

    assign m0_waitrequest = ~(cmd_ok & (grant == REQ0)) | ds_waitrequest | blocked;
    assign m1_waitrequest = ~(cmd_ok & (grant == REQ1)) | ds_waitrequest | blocked;

    assign accept = (ds_read | ds_write) & ~ds_waitrequest;
    assign push   = ds_read & ~ds_waitrequest;

    // Read data is broadcast; only the valid strobe is steered to the issuing requester
    assign m0_readdata      = ds_readdata;
    assign m1_readdata      = ds_readdata;
    assign m0_readdatavalid = pop & (pop_id == REQ0) & ~in_rst;
    assign m1_readdatavalid = pop & (pop_id == REQ1) & ~in_rst;

    resp_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (grant),
        .dout  (pop_id),
        .count (count)
    );

    // Arbitration state: lock follows a stalled command, last follows each accept
    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= 1'b0;
            lock_id <= REQ0;
            last    <= REQ1;
        end else begin
            locked <= (ds_read | ds_write) & ds_waitrequest;
            if ((ds_read | ds_write) & ds_waitrequest) begin
                lock_id <= grant;
            end
            if (accept) begin
                last <= grant;
            end
        end
    end

    // Sticky flag for a response arriving with nothing outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (ds_readdatavalid && (count == '0)) begin
            resp_err <= 1'b1;
        end
    end

endmodule
